// File: rtl/ctrl_ciclo_if.sv
// Sensor, program-select and actuator signals of the wash-cycle controller.
// The bench drives through master; the controller attaches through slave.
interface ctrl_ciclo_if #(
    parameter int CNT_W = 8
);
    logic             echeio;
    logic             sa;
    logic             se;
    logic             temp;
    logic [2:0]       acss;
    logic             ack;
    logic [6:0]       saida;
    logic [2:0]       estado;
    logic             falha;
    logic [CNT_W-1:0] ciclos;

    modport master (
        output echeio, sa, se, temp, acss, ack,
        input  saida, estado, falha, ciclos
    );

    modport slave (
        input  echeio, sa, se, temp, acss, ack,
        output saida, estado, falha, ciclos
    );
endinterface

// File: rtl/ctrl_ciclo.sv
// Fill/drain/heat cycle controller with per-phase timeout and a completed-program
// counter. Actuator pattern is registered from the next state so it tracks estado.
module ctrl_ciclo #(
    parameter int T_W    = 16,
    parameter int T_FILL = 1000,
    parameter int T_HEAT = 5000,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_ciclo_if.slave  bus_io
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_SELECT = 3'd2,
        S_FILL   = 3'd3,
        S_DRAIN  = 3'd4,
        S_HEAT   = 3'd5,
        S_FULL   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [T_W-1:0] FILL_LAST = T_W'(T_FILL - 1);
    localparam logic [T_W-1:0] HEAT_LAST = T_W'(T_HEAT - 1);

    if (longint'(T_FILL) >= (longint'(1) << T_W)) begin : g_bad_t_fill
        $error("ctrl_ciclo: T_FILL does not fit in T_W bits");
    end
    if (longint'(T_HEAT) >= (longint'(1) << T_W)) begin : g_bad_t_heat
        $error("ctrl_ciclo: T_HEAT does not fit in T_W bits");
    end

    state_t           state_q, state_d;
    logic [T_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0] ciclos_q, ciclos_d;
    logic [6:0]       saida_q, saida_d;
    logic             done;

    // Normal exits are tested before the timeout so they win a same-cycle tie.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus_io.echeio)                       state_d = S_FULL;
                else if (bus_io.sa && !bus_io.se)        state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus_io.acss != 3'b000)               state_d = S_SELECT;
                else if (!bus_io.sa)                     state_d = S_IDLE;
            end
            S_SELECT: begin
                if (bus_io.echeio)                       state_d = S_FULL;
                else if (bus_io.acss == 3'b100 && bus_io.sa && !bus_io.se)
                                                         state_d = S_FILL;
                else if (bus_io.acss == 3'b001)          state_d = S_HEAT;
                else if (bus_io.acss == 3'b010)          state_d = S_IDLE;
            end
            S_FILL: begin
                if (bus_io.echeio)                       state_d = S_FULL;
                else if (bus_io.sa && bus_io.se)         state_d = S_DRAIN;
                else if (!bus_io.sa && !bus_io.se)       state_d = S_IDLE;
                else if (timer_q == FILL_LAST)           state_d = S_FAULT;
            end
            S_DRAIN: begin
                if (bus_io.echeio)                       state_d = S_FULL;
                else if (!bus_io.se) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            S_HEAT: begin
                if (!bus_io.temp) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end else if (timer_q == HEAT_LAST)       state_d = S_FAULT;
            end
            S_FULL: begin
                if (!bus_io.echeio)                      state_d = S_IDLE;
            end
            S_FAULT: begin
                if (bus_io.ack && !bus_io.echeio)        state_d = S_IDLE;
            end
            default:                                     state_d = S_IDLE;
        endcase
    end

    // Timer only runs inside a timed phase and saturates instead of wrapping.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q && (state_q == S_FILL || state_q == S_HEAT)) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        end
    end

    always_comb begin
        ciclos_d = ciclos_q + CNT_W'(done);
    end

    always_comb begin
        saida_d = 7'b0000000;
        unique case (state_d)
            S_IDLE:   saida_d = 7'b0000000;
            S_ARMED:  saida_d = 7'b1000000;
            S_SELECT: saida_d = 7'b0000000;
            S_FILL:   saida_d = 7'b0101011;
            S_DRAIN:  saida_d = 7'b0011001;
            S_HEAT:   saida_d = 7'b0010100;
            S_FULL:   saida_d = 7'b0000010;
            S_FAULT:  saida_d = 7'b1111111;
            default:  saida_d = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            ciclos_q <= '0;
            saida_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ciclos_q <= ciclos_d;
            saida_q  <= saida_d;
        end
    end

    assign bus_io.saida  = saida_q;
    assign bus_io.estado = state_q;
    assign bus_io.falha  = (state_q == S_FAULT);
    assign bus_io.ciclos = ciclos_q;
endmodule

// File: tb/tb_ctrl_ciclo.sv
// Directed vector bench for ctrl_ciclo: table of single-cycle steps, then
// timeout, tie-break, asynchronous reset and counter wrap sequences.
module tb_ctrl_ciclo;
    localparam int CNT_W = 2;

    localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, SELECT = 3'd2, FILL = 3'd3,
                           DRAIN = 3'd4, HEAT = 3'd5, FULL = 3'd6, FAULT = 3'd7;

    typedef struct packed {
        logic             echeio;
        logic             sa;
        logic             se;
        logic             temp;
        logic [2:0]       acss;
        logic             ack;
        logic [2:0]       st;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic [CNT_W-1:0] cnt_exp;

    ctrl_ciclo_if #(.CNT_W(CNT_W)) bus ();

    ctrl_ciclo #(
        .T_W    (8),
        .T_FILL (8),
        .T_HEAT (16),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] pat(input logic [2:0] st);
        case (st)
            ARMED:   return 7'b1000000;
            FILL:    return 7'b0101011;
            DRAIN:   return 7'b0011001;
            HEAT:    return 7'b0010100;
            FULL:    return 7'b0000010;
            FAULT:   return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic [CNT_W-1:0] cnt);
        logic [6:0] sx;
        logic       fx;
        sx = pat(st);
        fx = (st == FAULT);
        n_vec++;
        if (bus.estado !== st || bus.saida !== sx || bus.falha !== fx || bus.ciclos !== cnt) begin
            n_bad++;
            $display("FAIL %s: got estado=%0d saida=%b falha=%b ciclos=%0d, want estado=%0d saida=%b falha=%b ciclos=%0d",
                     name, bus.estado, bus.saida, bus.falha, bus.ciclos, st, sx, fx, cnt);
        end else begin
            $display("ok   %s: estado=%0d saida=%b falha=%b ciclos=%0d",
                     name, bus.estado, bus.saida, bus.falha, bus.ciclos);
        end
    endtask

    task automatic apply(input string name, input logic e, input logic a, input logic s,
                         input logic t, input logic [2:0] sel, input logic k,
                         input logic [2:0] st, input logic [CNT_W-1:0] cnt);
        bus.echeio = e;
        bus.sa     = a;
        bus.se     = s;
        bus.temp   = t;
        bus.acss   = sel;
        bus.ack    = k;
        @(posedge clk);
        #1;
        check(name, st, cnt);
    endtask

    task automatic enter_fill(input string name);
        apply({name, ".armed"},  0, 1, 0, 0, 3'b000, 0, ARMED,  cnt_exp);
        apply({name, ".select"}, 0, 1, 0, 0, 3'b100, 0, SELECT, cnt_exp);
        apply({name, ".fill"},   0, 1, 0, 0, 3'b100, 0, FILL,   cnt_exp);
    endtask

    task automatic enter_heat(input string name);
        apply({name, ".armed"},  0, 1, 0, 1, 3'b000, 0, ARMED,  cnt_exp);
        apply({name, ".select"}, 0, 1, 0, 1, 3'b001, 0, SELECT, cnt_exp);
        apply({name, ".heat"},   0, 1, 0, 1, 3'b001, 0, HEAT,   cnt_exp);
    endtask

    task automatic full_program(input string name);
        enter_fill(name);
        apply({name, ".drain"}, 0, 1, 1, 0, 3'b000, 0, DRAIN, cnt_exp);
        cnt_exp = cnt_exp + 1'b1;
        apply({name, ".done"},  0, 0, 0, 0, 3'b000, 0, IDLE,  cnt_exp);
    endtask

    vec_t vecs[27];

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        cnt_exp = '0;

        //                e  sa se t  acss    ack st      cnt
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, ARMED,  2'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, SELECT, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, FILL,   2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, DRAIN,  2'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, DRAIN,  2'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, IDLE,   2'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, ARMED,  2'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, SELECT, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, HEAT,   2'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, HEAT,   2'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, HEAT,   2'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, IDLE,   2'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, ARMED,  2'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, IDLE,   2'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, ARMED,  2'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, SELECT, 2'd2};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, SELECT, 2'd2};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, IDLE,   2'd2};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, ARMED,  2'd2};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, SELECT, 2'd2};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, FILL,   2'd2};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, FULL,   2'd2};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, FULL,   2'd2};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, IDLE,   2'd2};
        vecs[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, FULL,   2'd2};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, IDLE,   2'd2};
        vecs[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, IDLE,   2'd2};

        rst        = 1'b1;
        bus.echeio = 1'b0;
        bus.sa     = 1'b0;
        bus.se     = 1'b0;
        bus.temp   = 1'b0;
        bus.acss   = 3'b000;
        bus.ack    = 1'b0;
        #12;
        check("reset", IDLE, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].echeio, vecs[i].sa, vecs[i].se,
                  vecs[i].temp, vecs[i].acss, vecs[i].ack, vecs[i].st, vecs[i].cnt);
        end
        cnt_exp = 2'd2;

        // Fill timeout: FILL entered with timer 0, faults on the 8th edge.
        enter_fill("ftmo");
        for (int i = 1; i < 8; i++)
            apply($sformatf("ftmo.hold%0d", i), 0, 1, 0, 0, 3'b000, 0, FILL, cnt_exp);
        apply("ftmo.fault",    0, 1, 0, 0, 3'b000, 0, FAULT, cnt_exp);
        apply("ftmo.ack_full", 1, 0, 0, 0, 3'b000, 1, FAULT, cnt_exp);
        apply("ftmo.noack",    0, 0, 0, 0, 3'b000, 0, FAULT, cnt_exp);
        apply("ftmo.ack",      0, 0, 0, 0, 3'b000, 1, IDLE,  cnt_exp);

        // Drain request on the timeout cycle must win over the fault.
        enter_fill("ftie");
        for (int i = 1; i < 8; i++)
            apply($sformatf("ftie.hold%0d", i), 0, 1, 0, 0, 3'b000, 0, FILL, cnt_exp);
        apply("ftie.drain", 0, 1, 1, 0, 3'b000, 0, DRAIN, cnt_exp);
        cnt_exp = cnt_exp + 1'b1;
        apply("ftie.done",  0, 0, 0, 0, 3'b000, 0, IDLE,  cnt_exp);

        enter_heat("htmo");
        for (int i = 1; i < 16; i++)
            apply($sformatf("htmo.hold%0d", i), 0, 0, 0, 1, 3'b000, 0, HEAT, cnt_exp);
        apply("htmo.fault", 0, 0, 0, 1, 3'b000, 0, FAULT, cnt_exp);
        apply("htmo.ack",   0, 0, 0, 1, 3'b000, 1, IDLE,  cnt_exp);

        enter_heat("htie");
        for (int i = 1; i < 16; i++)
            apply($sformatf("htie.hold%0d", i), 0, 0, 0, 1, 3'b000, 0, HEAT, cnt_exp);
        cnt_exp = cnt_exp + 1'b1;
        apply("htie.done", 0, 0, 0, 0, 3'b000, 0, IDLE, cnt_exp);

        // Reset pulse between edges while in DRAIN.
        enter_fill("arst");
        apply("arst.drain", 0, 1, 1, 0, 3'b000, 0, DRAIN, cnt_exp);
        #2 rst = 1'b1;
        #1;
        cnt_exp = '0;
        check("arst.async", IDLE, cnt_exp);
        #2 rst = 1'b0;
        apply("arst.stay", 0, 1, 1, 0, 3'b000, 0, IDLE, cnt_exp);
        apply("arst.idle", 0, 0, 0, 0, 3'b000, 0, IDLE, cnt_exp);

        for (int p = 0; p < 4; p++)
            full_program($sformatf("wrap%0d", p));
        check("wrap.final", IDLE, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_ciclo.md
CTRL_CICLO -- requirements
Module: ctrl_ciclo

Parameters
REQ-001 SHALL provide parameter T_W, default 16: width of the phase timer.
REQ-002 SHALL provide parameter T_FILL, default 1000: maximum cycles allowed in FILL before a fault is raised.
REQ-003 SHALL provide parameter T_HEAT, default 5000: maximum cycles allowed in HEAT before a fault is raised.
REQ-004 SHALL provide parameter CNT_W, default 8: width of the completed-cycle counter.

Interface
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 echeio  in  1  tank-full / overflow sensor.
REQ-008 sa  in  1  inlet sensor.
REQ-009 se  in  1  outlet sensor.
REQ-010 temp  in  1  temperature-not-reached flag.
REQ-011 acss  in  3  program select, one-hot: [2]=fill, [1]=cancel, [0]=heat.
REQ-012 ack  in  1  operator fault acknowledge.
REQ-013 saida  out  7  actuator pattern, registered.
REQ-014 estado  out  3  current state code.
REQ-015 falha  out  1  high while in FAULT.
REQ-016 ciclos  out  CNT_W  count of completed programs.

Function
REQ-017 States and codes SHALL be: IDLE=0, ARMED=1, SELECT=2, FILL=3, DRAIN=4, HEAT=5, FULL=6, FAULT=7.
REQ-018 saida SHALL be a registered function of the next state, so saida always matches estado in the same cycle.
REQ-019 saida patterns SHALL be: IDLE 0000000, ARMED 1000000, SELECT 0000000, FILL 0101011, DRAIN 0011001, HEAT 0010100, FULL 0000010, FAULT 1111111.
REQ-020 IDLE transitions: echeio -> FULL; else sa & !se -> ARMED; else hold.
REQ-021 ARMED transitions: acss!=0 -> SELECT; else !sa -> IDLE; else hold.
REQ-022 SELECT transitions, in priority order: echeio -> FULL; acss==100 & sa & !se -> FILL; acss==001 -> HEAT; acss==010 -> IDLE; any other value holds.
REQ-023 FILL transitions: echeio -> FULL; sa & se -> DRAIN; !sa & !se -> IDLE; timer==T_FILL-1 -> FAULT; else hold.
REQ-024 DRAIN transitions: echeio -> FULL; !se -> IDLE and ciclos increments; else hold.
REQ-025 HEAT transitions: !temp -> IDLE and ciclos increments; timer==T_HEAT-1 -> FAULT; else hold.
REQ-026 In HEAT, echeio SHALL be ignored.
REQ-027 FULL transitions: !echeio -> IDLE; else hold.
REQ-028 FAULT transitions: ack & !echeio -> IDLE; else hold.
REQ-029 In FAULT, falha SHALL be 1; it SHALL be 0 in every other state.
REQ-030 Timer SHALL clear on every state change and increment by 1 per cycle while in FILL or HEAT.
REQ-031 Timer SHALL hold at 0 in all other states and SHALL never wrap.
REQ-032 ciclos SHALL wrap modulo 2^CNT_W, with no saturation.
REQ-033 When a timeout and a normal exit condition occur in the same cycle, the normal exit SHALL win.
REQ-034 Parameter values T_FILL or T_HEAT >= 2^T_W are illegal and SHALL be flagged by a simulation-time check.

Reset
REQ-035 rst asserted SHALL immediately force: state IDLE, saida 0000000, estado 0, falha 0, timer 0, ciclos 0, independent of clk.
REQ-036 Reset asserted in any state, including mid-FILL or FAULT, SHALL abort the operation with no ciclos increment.
REQ-037 The first transition after reset SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-038 Normal fill: rst, then sa=1 -> ARMED; acss=100 -> SELECT, then FILL with saida=0101011; se=1 -> DRAIN with saida=0011001; se=0 -> IDLE with ciclos=1.
REQ-039 Fill timeout: with T_FILL=8, hold FILL inputs -> FAULT on the 8th cycle, falha=1, saida=1111111; ack=1 -> IDLE.
REQ-040 Heat path: acss=001 with temp=1 -> HEAT; temp=0 at cycle 3 -> IDLE, ciclos increments, no fault.
REQ-041 Overflow: echeio=1 during FILL -> FULL on the next edge; FAULT held with echeio=1 and ack=1 stays in FAULT.
REQ-042 Asynchronous reset: rst pulse between edges during DRAIN -> outputs zero before the next edge; ciclos not incremented.
REQ-043 Wrap: with CNT_W=2, run 4 full programs -> ciclos reads 0.
